audio_fetch_pwm: RTL and testbench
==================================

AUDIO_FETCH_PWM -- requirements
Module: audio_fetch_pwm

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, giving the system clock frequency in Hz.
REQ-002 The block SHALL have parameter SAMPLE_HZ, default 3000, giving the sample rate (address rate) in Hz.
REQ-003 The block SHALL have parameter ADDR_W, default 22, giving the in-song address width.
REQ-004 The block SHALL have parameter SONG_W, default 2, giving the song-select width.
REQ-005 The block SHALL have the following ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-high.
- play  input  1  1 = playing; 0 = paused and muted.
- endereco  input  ADDR_W  current in-song address from the address state machine.
- prox_musica  input  1  one-cycle end-of-song pulse from the address state machine.
- sample_tick  output  1  one-cycle advance pulse; drives the address state machine count input.
- mem_req  output  1  memory read request.
- mem_addr  output  SONG_W+ADDR_W  {musica, endereco} read address.
- mem_ack  input  1  read done, with mem_data valid in the same cycle.
- mem_data  input  8  unsigned sample byte.
- musica  output  SONG_W  current song index.
- pwm_out  output  1  PWM audio output.
- overrun  output  1  sticky flag: a sample fetch missed its slot.

Function
REQ-006 The tick divider SHALL count 0..DIV-1, where DIV = CLK_HZ/SAMPLE_HZ (integer), advancing only while play=1 and holding its value while play=0.
REQ-007 sample_tick SHALL pulse high for exactly one cycle when the divider wraps from DIV-1 to 0.
REQ-008 The fetch FSM SHALL have states IDLE, SETTLE and REQ.
REQ-009 In IDLE, a sample_tick SHALL move the FSM to SETTLE.
REQ-010 SETTLE SHALL last exactly one cycle, giving the upstream address one cycle to update, and SHALL then move to REQ.
REQ-011 On entry to REQ, the FSM SHALL assert mem_req and register mem_addr = {musica, endereco}.
REQ-012 mem_req and mem_addr SHALL be held stable until mem_ack is sampled high.
REQ-013 On mem_ack in REQ, the FSM SHALL latch mem_data into the pending sample register, deassert mem_req in the next cycle and return to IDLE.
REQ-014 mem_ack outside REQ SHALL be ignored.
REQ-015 If sample_tick occurs while the FSM is in SETTLE or REQ, the tick SHALL be dropped (not queued), overrun SHALL be set and held until reset, and the current fetch SHALL continue.
REQ-016 If play falls during REQ, the handshake SHALL still complete; no new fetch SHALL start while play=0.
REQ-017 On each prox_musica pulse, musica SHALL increment by 1, wrapping from 2^SONG_W-1 to 0.
REQ-018 If prox_musica coincides with a mem_addr capture, the capture SHALL use the old musica value.
REQ-019 The PWM SHALL use a free-running 8-bit counter pwm_cnt (0..255, wraps).
REQ-020 The active sample SHALL be loaded from the pending sample register only on the cycle pwm_cnt wraps 255->0 (glitch-free double buffer).
REQ-021 pwm_out SHALL be registered and equal (pwm_cnt < active) while play=1.
REQ-022 pwm_out SHALL be 0 while play=0.
REQ-023 An active sample of 0 SHALL give constant 0; an active sample of 255 SHALL give 255 high cycles out of 256.

Reset
REQ-024 While reset=1, regardless of clk, the following SHALL all be 0: divider, pwm_cnt, pending sample, active sample, musica, overrun, sample_tick, mem_req, mem_addr and pwm_out; the FSM SHALL be in IDLE.
REQ-025 Reset asserted mid-handshake SHALL abort the fetch with no data latched.
REQ-026 After reset release, the first sample_tick SHALL occur DIV cycles after play is first sampled high.

Structure
REQ-027 A shared package audio_pkg SHALL hold CLK_HZ, SAMPLE_HZ, ADDR_W, SONG_W, the derived DIV and the FSM state encoding (IDLE=2'd0, SETTLE=2'd1, REQ=2'd2).
REQ-028 The PWM counter, double buffer and comparator SHALL be one sub-module, pwm_dac (inputs clk, reset, en, sample[7:0]; output pwm_out).
REQ-029 The divider, FSM and musica register SHALL reside in audio_fetch_pwm.

Verification (simulate with CLK_HZ=30000, SAMPLE_HZ=3000, so DIV=10)
REQ-030 The bench SHALL cover: reset release then play=1 -> sample_tick at cycle 10, 20, 30; with mem_ack one cycle after mem_req -> mem_req at cycles 12..13, mem_addr={0,endereco}.
REQ-031 The bench SHALL cover: mem_data=8'd64 acked -> after the next pwm_cnt wrap, pwm_out high for exactly 64 of each 256 cycles; mem_data=0 -> pwm_out constant 0; mem_data=255 -> pwm_out low 1 cycle per 256.
REQ-032 The bench SHALL cover: mem_ack withheld 15 cycles -> the second tick is dropped, overrun=1 and stays 1; the fetch completes on ack; the next fetch starts at the following tick.
REQ-033 The bench SHALL cover: prox_musica pulsed 5 times -> musica counts 1,2,3,0,1; a later capture gives mem_addr[23:22]=1.
REQ-034 The bench SHALL cover: play=0 at divider=4 for 50 cycles -> no ticks, pwm_out=0; play=1 -> next tick 6 cycles later.
REQ-035 The bench SHALL cover: reset pulsed with mem_req high -> mem_req=0 immediately, pending sample unchanged at 0, FSM IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio fetch/PWM block.
// Holds the default clock and sample rates, the address and song widths,
// the derived divider ratio, and the fetch FSM state encoding.
package audio_pkg;
  localparam int CLK_HZ    = 50_000_000;
  localparam int SAMPLE_HZ = 3000;
  localparam int ADDR_W    = 22;
  localparam int SONG_W    = 2;
  localparam int DIV       = CLK_HZ / SAMPLE_HZ;

  // Fetch FSM encoding. Kept as plain constants so older code that compares
  // raw state bits keeps working.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_REQ    = 2'd2;
endpackage

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC with a glitch-free double buffer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : 1 = output enabled, 0 = output forced low
//   sample     : pending sample, taken into the active register at counter wrap
//   pwm_out    : registered PWM output, high while pwm_cnt < active
module pwm_dac (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] sample,
  output logic       pwm_out
);
  logic [7:0] pwm_cnt;
  logic [7:0] active;

  // The active sample only changes at the 255->0 wrap so a period is never
  // split between two duty values. Sample 255 gives 255/256 high; a full
  // 256/256 duty is not representable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
      active  <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) active <= sample;
      pwm_out <= en && (pwm_cnt < active);
    end
  end
endmodule

// File: rtl/audio_fetch_pwm.sv
// Audio sample fetcher driving an 8-bit PWM output.
// A divider produces one sample_tick per sample period while playing. Each
// tick starts a fetch: one settle cycle for the upstream address, then a
// req/ack read of {musica, endereco}. The fetched byte feeds the PWM DAC.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   play         : 1 = playing, 0 = paused (divider holds, output muted)
//   endereco     : in-song address from the address state machine
//   prox_musica  : end-of-song pulse, advances musica
//   sample_tick  : one-cycle advance pulse to the address state machine
//   mem_req/addr : read request and address, held until mem_ack
//   mem_ack/data : read completion with data valid in the same cycle
//   musica       : current song index
//   pwm_out      : PWM audio output
//   overrun      : sticky, set when a tick arrives while a fetch is busy
module audio_fetch_pwm
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = audio_pkg::CLK_HZ,
  parameter int SAMPLE_HZ = audio_pkg::SAMPLE_HZ,
  parameter int ADDR_W    = audio_pkg::ADDR_W,
  parameter int SONG_W    = audio_pkg::SONG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [ADDR_W-1:0]        endereco,
  input  logic                     prox_musica,
  output logic                     sample_tick,
  output logic                     mem_req,
  output logic [SONG_W+ADDR_W-1:0] mem_addr,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_data,
  output logic [SONG_W-1:0]        musica,
  output logic                     pwm_out,
  output logic                     overrun
);
  localparam int DIV_R = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = (DIV_R > 1) ? $clog2(DIV_R) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_R - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       state;
  logic [7:0]       pending;

  // Sample-rate divider. Holding (not clearing) on pause means a resumed
  // song keeps its sample phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      if (play) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt     <= '0;
          sample_tick <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // Fetch FSM. A tick that lands while a fetch is in flight is dropped and
  // flagged rather than queued: a late sample is worse than a skipped one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pending  <= 8'd0;
      overrun  <= 1'b0;
    end else begin
      if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (sample_tick && play) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // endereco has had a cycle to follow the tick; musica here is the
          // pre-increment value if prox_musica fires this same cycle.
          state    <= ST_REQ;
          mem_req  <= 1'b1;
          mem_addr <= {musica, endereco};
        end
        ST_REQ: begin
          // The handshake finishes even if play drops meanwhile.
          if (mem_ack) begin
            pending <= mem_data;
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            musica <= '0;
    else if (prox_musica) musica <= musica + 1'b1;
  end

  pwm_dac u_pwm_dac (
    .clk     (clk),
    .reset   (reset),
    .en      (play),
    .sample  (pending),
    .pwm_out (pwm_out)
  );
endmodule

// File: tb/tb_audio_fetch_pwm.sv
module tb_audio_fetch_pwm;
  localparam int DIV = 10;
  localparam int AW  = 22;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          reset, play, prox_musica, mem_ack;
  logic [AW-1:0] endereco;
  logic [7:0]    mem_data;
  logic          sample_tick, mem_req, pwm_out, overrun;
  logic [SW+AW-1:0] mem_addr;
  logic [SW-1:0] musica;

  always #5 clk = ~clk;

  audio_fetch_pwm #(.CLK_HZ(30000), .SAMPLE_HZ(3000), .ADDR_W(AW), .SONG_W(SW)) dut (
    .clk(clk), .reset(reset), .play(play), .endereco(endereco),
    .prox_musica(prox_musica), .sample_tick(sample_tick), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .musica(musica), .pwm_out(pwm_out), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: expressed as sample counts, a busy flag and
  // a sample phase, derived from the block's behavioural rules.
  int          edge_no, pc, req_at, req_age, ack_lat;
  bit          m_tick, m_busy, m_req, m_ovr, m_pwm, spur, fixed_data;
  logic [23:0] m_addr;
  logic [1:0]  m_mus;
  logic [7:0]  pend, act, cnt, data_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_no = 0; pc = 0; req_at = 0; req_age = 0;
    m_tick = 0; m_busy = 0; m_req = 0; m_ovr = 0; m_pwm = 0;
    m_addr = '0; m_mus = '0; pend = 0; act = 0; cnt = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"}, 32'(sample_tick), 32'd0);
    chk({tag, "_req"},  32'(mem_req),     32'd0);
    chk({tag, "_addr"}, 32'(mem_addr),    32'd0);
    chk({tag, "_mus"},  32'(musica),      32'd0);
    chk({tag, "_pwm"},  32'(pwm_out),     32'd0);
    chk({tag, "_ovr"},  32'(overrun),     32'd0);
  endtask

  // One clock: drive inputs, advance the model by one edge, check outputs.
  task automatic step();
    bit was;
    endereco = AW'($urandom);
    if (m_req) mem_ack = (req_age >= ack_lat);
    else       mem_ack = spur && ($urandom_range(3) == 0);
    mem_data = fixed_data ? data_val : 8'($urandom);
    @(posedge clk);
    edge_no++;
    // PWM: compare against the current active sample, reload at wrap
    m_pwm = play && (cnt < act);
    if (cnt == 8'd255) act = pend;
    cnt = cnt + 8'd1;
    // A visible tick either starts a fetch or, if one is busy, is an overrun
    if (m_tick) begin
      if (m_busy) m_ovr = 1;
      else if (play) begin m_busy = 1; req_at = edge_no + 1; end
    end
    was = m_req;
    if (m_req && mem_ack) begin
      pend = mem_data; m_req = 0; m_busy = 0;
    end else if (m_busy && !m_req && edge_no == req_at) begin
      m_req = 1; m_addr = {m_mus, endereco};
    end
    if (prox_musica) m_mus = m_mus + 2'd1;
    if (play) begin pc++; m_tick = (pc % DIV == 0); end
    else m_tick = 0;
    req_age = (m_req && was) ? req_age + 1 : 0;
    #1;
    chk("tick", 32'(sample_tick), 32'(m_tick));
    chk("req",  32'(mem_req),     32'(m_req));
    chk("addr", 32'(mem_addr),    32'(m_addr));
    chk("mus",  32'(musica),      32'(m_mus));
    chk("ovr",  32'(overrun),     32'(m_ovr));
    chk("pwm",  32'(pwm_out),     32'(m_pwm));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pwm_window(input string tag, input int exp_hi);
    int hi = 0;
    for (int i = 0; i < 256; i++) begin step(); hi += int'(pwm_out); end
    chk(tag, 32'(hi), 32'(exp_hi));
  endtask

  initial begin
    int first_tick, first_req, req_fall, cnt_t, found;
    int mus_exp[5];
    mus_exp = '{1, 2, 3, 0, 1};
    reset = 1; play = 0; prox_musica = 0; mem_ack = 0; mem_data = 0; endereco = 0;
    spur = 0; fixed_data = 1; data_val = 8'd64; ack_lat = 1;
    model_reset();
    #2;
    chk_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_zero("rst_rel");

    // First fetch timing, constant sample 64
    play = 1;
    first_tick = 0; first_req = 0; req_fall = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sample_tick && first_tick == 0) first_tick = i;
      if (mem_req && first_req == 0) first_req = i;
      if (!mem_req && first_req != 0 && req_fall == 0) req_fall = i;
    end
    chk("first_tick", 32'(first_tick), 32'd10);
    chk("first_req",  32'(first_req),  32'd12);
    chk("req_fall",   32'(req_fall),   32'd14);
    run(300);
    pwm_window("pwm64", 64);

    data_val = 8'd0;   run(300); pwm_window("pwm0", 0);
    data_val = 8'd255; run(300); pwm_window("pwm255", 255);

    // Slow memory: ticks land mid-fetch
    ack_lat = 15; run(60);
    chk("ovr_set", 32'(overrun), 32'd1);
    ack_lat = 1; run(60);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Song counter with wrap, then a capture under song 1
    fixed_data = 0;
    for (int k = 0; k < 5; k++) begin
      prox_musica = 1; step(); prox_musica = 0;
      chk("mus_seq", 32'(musica), 32'(mus_exp[k]));
      run($urandom_range(4));
    end
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (mem_req) found = 1;
    end
    chk("cap_found", 32'(found), 32'd1);
    chk("cap_song", 32'(mem_addr[23:22]), 32'd1);

    // Pause at divider phase 4
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (pc % DIV == 4) found = 1; else step();
    end
    chk("pause_phase", 32'(found), 32'd1);
    play = 0; cnt_t = 0; found = 0;
    for (int i = 0; i < 50; i++) begin
      step(); cnt_t += int'(sample_tick); found += int'(pwm_out);
    end
    chk("pause_ticks", 32'(cnt_t), 32'd0);
    chk("pause_pwm",   32'(found), 32'd0);
    play = 1; first_tick = 0;
    for (int i = 1; i <= 20 && first_tick == 0; i++) begin
      step();
      if (sample_tick) first_tick = i;
    end
    chk("resume_tick", 32'(first_tick), 32'd6);

    // Randomized traffic: random data, latencies, stray acks, songs, pauses
    spur = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!m_req && $urandom_range(7) == 0) ack_lat = $urandom_range(6);
      if ($urandom_range(49) == 0) play = ~play;
      prox_musica = ($urandom_range(39) == 0);
      step();
    end
    prox_musica = 0; play = 1; spur = 0;

    // Asynchronous reset in the middle of a handshake
    ack_lat = 100; found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (mem_req) found = 1;
    end
    chk("mid_req_seen", 32'(found), 32'd1);
    reset = 1;
    #1;
    chk_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    ack_lat = 1; play = 0;
    run(20);
    play = 1;
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
